// File: rtl/icache_dm.sv
//------------------------------------------------------------------------------
// icache_dm : direct-mapped instruction cache, 1-cycle hit, beat-serial refill.
// Optional hit/miss counters enabled by macro ICACHE_STATS_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache_dm #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OB    = $clog2(LINE_WORDS);
  localparam int IB    = $clog2(LINES);
  localparam int WA_W  = ADDR_W - 2;
  localparam int TAG_W = WA_W - OB - IB;
  localparam logic [OB-1:0] LAST_BEAT = OB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, REPLY} state_t;

  state_t            state_q;
  logic [WA_W-1:0]   waddr_q;
  logic [OB-1:0]     beat_q;
  logic [LINES-1:0]  valid_q;
  logic              flush_pend_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*LINE_WORDS];

  logic [OB-1:0]     off;
  logic [IB-1:0]     idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              flush_now;
  logic              accept;
  logic              beat_we;
  logic              unused_bits;

  assign off = waddr_q[OB-1:0];
  assign idx = waddr_q[OB+IB-1:OB];
  assign tag = waddr_q[WA_W-1:OB+IB];
  assign unused_bits = ^cpu_addr[1:0];

  assign hit       = (state_q == LOOKUP) && valid_q[idx] && (tag_q[idx] == tag);
  assign flush_now = (state_q == IDLE) && (flush || flush_pend_q);
  assign beat_we   = (state_q == REFILL) && mem_rvalid;

  // A hit frees the request slot in the same cycle so hits can stream.
  assign cpu_ready  = !rst && (((state_q == IDLE) && !(flush || flush_pend_q)) || hit);
  assign accept     = cpu_req && cpu_ready;
  assign cpu_rvalid = !rst && (hit || (state_q == REPLY));
  assign cpu_rdata  = cpu_rvalid ? data_q[{idx, off}] : '0;
  assign mem_req    = !rst && (state_q == REFILL);
  assign mem_addr   = mem_req ? {tag, idx, {(OB+2){1'b0}}} : '0;

  always_ff @(posedge clk) begin
    if (beat_we) begin
      data_q[{idx, beat_q}] <= mem_rdata;
      if (beat_q == LAST_BEAT) tag_q[idx] <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      beat_q       <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // A flush arriving mid-transaction waits for the first IDLE cycle.
      if (flush_now)
        flush_pend_q <= 1'b0;
      else if (flush && (state_q != IDLE))
        flush_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (flush_now) begin
            valid_q <= '0;
          end else if (accept) begin
            waddr_q <= cpu_addr[ADDR_W-1:2];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (accept) waddr_q <= cpu_addr[ADDR_W-1:2];
            else        state_q <= IDLE;
          end else begin
            beat_q  <= '0;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              valid_q[idx] <= 1'b1;
              state_q      <= REPLY;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (!hit && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
//------------------------------------------------------------------------------
// tb_icache_dm : directed self-checking bench for icache_dm (default geometry).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  icache_dm #(.LINES(64), .LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one line of beats d0..d0+3, checking the request each beat.
  task automatic refill(input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      chk("refill_req", {63'd0, mem_req}, 64'd1);
      chk("refill_addr", {32'd0, mem_addr}, {32'd0, base});
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + i;
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
  endtask

  // Issues one fetch from IDLE and checks it misses in LOOKUP.
  task automatic fetch_miss(input string tag, input logic [31:0] addr);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #1;
    chk({tag, "_ready"}, {63'd0, cpu_ready}, 64'd1);
    tick();
    cpu_req = 1'b0;
    #1;
    chk({tag, "_lookup_rvalid"}, {63'd0, cpu_rvalid}, 64'd0);
    chk({tag, "_lookup_ready"}, {63'd0, cpu_ready}, 64'd0);
    tick();
  endtask

  task automatic reply(input string tag, input logic [31:0] exp);
    chk({tag, "_rvalid"}, {63'd0, cpu_rvalid}, 64'd1);
    chk({tag, "_rdata"}, {32'd0, cpu_rdata}, {32'd0, exp});
    chk({tag, "_memreq_low"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_ready_low"}, {63'd0, cpu_ready}, 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    tick();
    chk("rst_ready", {63'd0, cpu_ready}, 64'd0);
    chk("rst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
    chk("rst_memreq", {63'd0, mem_req}, 64'd0);
    chk("rst_memaddr", {32'd0, mem_addr}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, cpu_ready}, 64'd1);
`ifdef ICACHE_STATS_EN
    chk("rst_hits", {32'd0, hit_count}, 64'd0);
    chk("rst_miss", {32'd0, miss_count}, 64'd0);
`endif

    // 1. Cold miss
    fetch_miss("cold", 32'h100);
    refill(32'h100, 32'hA0);
    reply("cold", 32'hA0);

    // 2. Back-to-back hits
    cpu_req = 1'b1; cpu_addr = 32'h104;
    tick();
    cpu_addr = 32'h108;
    #1;
    chk("hit1_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("hit1_rdata", {32'd0, cpu_rdata}, 64'hA1);
    chk("hit1_ready", {63'd0, cpu_ready}, 64'd1);
    tick();
    cpu_addr = 32'h10C;
    #1;
    chk("hit2_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("hit2_rdata", {32'd0, cpu_rdata}, 64'hA2);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("hit3_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("hit3_rdata", {32'd0, cpu_rdata}, 64'hA3);
    chk("hit3_memreq", {63'd0, mem_req}, 64'd0);
    tick();
    chk("hit_idle_rvalid", {63'd0, cpu_rvalid}, 64'd0);

    // 3. Index conflict
    fetch_miss("conf", 32'h500);
    refill(32'h500, 32'hB0);
    reply("conf", 32'hB0);
    fetch_miss("evict", 32'h100);
    refill(32'h100, 32'hC0);
    reply("evict", 32'hC0);
`ifdef ICACHE_STATS_EN
    chk("stat_hits", {32'd0, hit_count}, 64'd3);
    chk("stat_miss", {32'd0, miss_count}, 64'd3);
`endif

    // 4. Flush in IDLE with a held request, then flush during refill
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h100;
    #1;
    chk("flush_ready", {63'd0, cpu_ready}, 64'd0);
    tick();
    flush = 1'b0; cpu_req = 1'b0;
    #1;
`ifdef ICACHE_STATS_EN
    chk("flush_hits", {32'd0, hit_count}, 64'd0);
    chk("flush_miss", {32'd0, miss_count}, 64'd0);
`endif
    fetch_miss("post_flush", 32'h100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    refill(32'h100, 32'hD0);
    reply("flush_refill", 32'hD0);
    chk("pend_flush_ready", {63'd0, cpu_ready}, 64'd0);
    tick();
    chk("after_pend_ready", {63'd0, cpu_ready}, 64'd1);
    fetch_miss("refetch", 32'h100);
    refill(32'h100, 32'hE0);
    reply("refetch", 32'hE0);

    // 5. Reset mid-refill
    fetch_miss("abort", 32'h504);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    tick();
    tick();
    mem_rvalid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_memreq", {63'd0, mem_req}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_memreq", {63'd0, mem_req}, 64'd0);
    chk("abort_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    chk("abort_ready", {63'd0, cpu_ready}, 64'd1);
    fetch_miss("after_rst", 32'h100);
    refill(32'h100, 32'hF0);
    reply("after_rst", 32'hF0);

    // Last word of the line hits
    cpu_req = 1'b1; cpu_addr = 32'h10C;
    tick();
    cpu_req = 1'b0;
    #1;
    chk("last_word_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("last_word_rdata", {32'd0, cpu_rdata}, 64'hF3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
